// File: rtl/vend_controller.sv
// Vending sequencer: coin credit, price check, dispenser handshake,
// change return, cancel, timeout refund and coin rejection.
module vend_controller #(
  parameter int PRICE_A    = 2,
  parameter int PRICE_B    = 3,
  parameter int MAX_CREDIT = 7,
  parameter int CREDIT_W   = 3,
  parameter int TIMEOUT    = 50,
  parameter int TO_W       = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic                sel_id,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic                disp_id,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                sel_err,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISPENSE,
    CHANGE
  } state_t;

  localparam logic [CREDIT_W-1:0] PA = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PB = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W:0] MAXC = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [TO_W-1:0] TLAST = TO_W'(TIMEOUT - 1);

  state_t              state;
  logic [TO_W-1:0]     tcnt;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] price;
  logic                coin_ok;
  logic                coin_any;
  logic                fits;
  logic                afford;

  always_comb begin
    coin_val = '0;
    unique case (1'b1)
      coin == 2'b01: coin_val = (CREDIT_W+1)'(1);
      coin == 2'b10: coin_val = (CREDIT_W+1)'(2);
      default: coin_val = '0;
    endcase
  end

  assign coin_ok  = (coin == 2'b01) || (coin == 2'b10);
  assign coin_any = (coin != 2'b00);
  assign sum      = {1'b0, credit} + coin_val;
  assign fits     = (sum <= MAXC);
  assign price    = sel_id ? PB : PA;
  assign afford   = (credit >= price);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      tcnt         <= '0;
      credit       <= '0;
      disp_req     <= 1'b0;
      disp_id      <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      sel_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      sel_err      <= 1'b0;
      unique case (state)
        IDLE: begin
          sel_err <= sel_valid;
          if (coin == 2'b11) begin
            coin_reject <= 1'b1;
          end else if (coin_ok) begin
            credit <= sum[CREDIT_W-1:0];
            tcnt   <= '0;
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (cancel) begin
            coin_reject <= coin_any;
            busy        <= 1'b1;
            state       <= CHANGE;
          end else if (sel_valid) begin
            coin_reject <= coin_any;
            if (afford) begin
              credit   <= credit - price;
              disp_id  <= sel_id;
              disp_req <= 1'b1;
              busy     <= 1'b1;
              state    <= DISPENSE;
            end else begin
              sel_err <= 1'b1;
              tcnt    <= '0;
            end
          end else if (coin_ok && fits) begin
            credit <= sum[CREDIT_W-1:0];
            tcnt   <= '0;
          end else begin
            // invalid or over-ceiling coins do not restart the idle timer
            coin_reject <= coin_any;
            if (tcnt == TLAST) begin
              busy  <= 1'b1;
              state <= CHANGE;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        DISPENSE: begin
          coin_reject <= coin_any;
          if (disp_ack) begin
            disp_req <= 1'b0;
            if (credit != '0) begin
              state <= CHANGE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        CHANGE: begin
          coin_reject <= coin_any;
          if (credit != '0) begin
            change_pulse <= 1'b1;
            credit       <= credit - 1'b1;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Sequencing controller for the vending datapath.
- Accumulates coin credit, accepts a product selection and checks it against a price table.
- Runs a req/ack handshake with the product dispenser, then returns change as unit pulses.
- Handles cancel, inactivity timeout with refund, and coin rejection.

Parameters:
PRICE_A, 2, price of product 0 in rupees
PRICE_B, 3, price of product 1 in rupees
MAX_CREDIT, 7, credit ceiling; must fit in CREDIT_W bits
CREDIT_W, 3, credit register width
TIMEOUT, 50, idle cycles in COLLECT before automatic refund
TO_W, 6, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-low reset
coin  in  2  coin code: 00 none, 01 one rupee, 10 two rupees, 11 invalid
sel_valid  in  1  one-cycle selection strobe
sel_id  in  1  product selected: 0 = A, 1 = B
cancel  in  1  one-cycle cancel strobe
disp_ack  in  1  dispenser done acknowledge
disp_req  out  1  dispense request
disp_id  out  1  product being dispensed
change_pulse  out  1  one rupee returned per high cycle
coin_reject  out  1  one-cycle pulse: coin returned un-credited
sel_err  out  1  one-cycle pulse: selection refused, insufficient credit
credit  out  CREDIT_W  current credit
busy  out  1  high in DISPENSE and CHANGE

Behaviour:
- All outputs are registered; each updates on the clk edge following the triggering input sample.
- Reset:
  - rst sampled low → state IDLE; credit, timeout counter and all outputs become 0.
  - Applies from any state, including mid-DISPENSE: disp_req drops and credit is forfeited, with no change pulses.
- Coin value: 01 → 1, 10 → 2, 11 → always coin_reject, never credited.
- IDLE:
  - credit = 0.
  - A valid coin sets credit to its value → COLLECT.
  - sel_valid → sel_err. cancel is ignored.
- COLLECT, per-cycle priority cancel > sel_valid > coin:
  - cancel → CHANGE.
  - sel_valid with credit ≥ price(sel_id):
    - credit ← credit − price, disp_id ← sel_id → DISPENSE.
  - sel_valid with credit < price:
    - sel_err pulse; stay in COLLECT with credit unchanged.
  - A coin arriving in the same cycle as cancel or sel_valid → coin_reject.
  - A coin that would make credit exceed MAX_CREDIT → coin_reject, credit unchanged.
  - Otherwise credit ← credit + value.
- Timeout counter (COLLECT only):
  - Clears on entry to COLLECT, on every accepted coin and on every sel_err; otherwise increments.
  - When it reaches TIMEOUT−1 with no event in that cycle → CHANGE.
  - Result: exactly TIMEOUT quiet cycles → refund.
- DISPENSE:
  - disp_req = 1 and disp_id is held stable until disp_ack is sampled high.
  - The next cycle disp_req = 0. Then credit > 0 → CHANGE, else → IDLE.
  - Coins are rejected; sel_valid and cancel are ignored.
  - disp_ack outside DISPENSE is ignored.
- CHANGE:
  - Each cycle with credit > 0: change_pulse = 1, credit ← credit − 1.
  - When credit = 0 → IDLE.
  - change_pulse is high for exactly N consecutive cycles, N = refund amount.
  - Coins are rejected; sel_valid and cancel are ignored.
- busy = 1 exactly in DISPENSE and CHANGE.
- No arithmetic wrap is allowed: the ceiling check prevents overflow and the price check prevents underflow.

Test Plan (defaults):
- Reset: hold rst = 0 for 2 cycles with coin = 01 → credit = 0, disp_req = 0, change_pulse = 0, busy = 0.
- Exact purchase: coin 01, 01 → credit = 2; sel_valid, sel_id = 0 → disp_req = 1, disp_id = 0; disp_ack after 3 cycles → disp_req = 0 the next cycle, zero change pulses, return to IDLE.
- Overpay with change: coin 10, 10 → credit = 4; select B → dispense id 1, credit = 1; ack → exactly 1 change_pulse, credit = 0.
- Refusal and cancel: coin 01; select B → sel_err pulse, credit = 1; cancel → 1 change_pulse, then IDLE.
- Ceiling and timeout: coin 10 ×4 → 4th coin gives coin_reject, credit = 6; coin 11 → coin_reject; 50 idle cycles → 6 consecutive change pulses.
- Collisions and reset mid-operation: coin 01 with cancel in the same cycle → coin_reject and refund of prior credit only; rst low during DISPENSE → disp_req = 0 next cycle, credit = 0, no change pulses.
